// File: rtl/wb_sram_arb2.sv
// wb_sram_arb2: two-master round-robin Wishbone arbiter in front of a single-port SRAM slave.
//
// Ownership is granted per Wishbone cycle and held while the owner keeps cyc high, so bursts
// and locked sequences are never split. The grant is registered (one cycle of arbitration
// latency); the slave-side bus is a combinational mux of the owning master's signals.
//
// Ports:
//   wb_clk_i, wb_rst_ni     clock, asynchronous active-low reset
//   m0_*_i / m1_*_i         master requests (adr, dat, sel, we, cyc, stb, cti, bte)
//   m0_*_o / m1_*_o         read data (shared copy of s_dat_i) and ack/err/rty terminations
//   s_*_o                   muxed request to the SRAM slave
//   s_dat_i, s_ack_i, s_err_i, s_rty_i   slave response
//
// Optional build macro WB_SRAM_ARB_STATS_EN adds stats_clr_i and two saturating 16-bit
// wait counters (m0_wait_cnt_o, m1_wait_cnt_o) counting cycles a master requests without
// owning the bus. Arbitration is identical in both builds.
module wb_sram_arb2 #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
`ifdef WB_SRAM_ARB_STATS_EN
    input  logic            stats_clr_i,
    output logic [15:0]     m0_wait_cnt_o,
    output logic [15:0]     m1_wait_cnt_o,
`endif
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i
);

    localparam int unsigned SW = DW / 8;

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    state_e state_q, state_d;
    logic   last_owner_q, last_owner_d;

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;  // master 0 wins the first contention
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            StIdle: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_owner_q ? StGrant0 : StGrant1;
                end else if (m0_cyc_i) begin
                    state_d = StGrant0;
                end else if (m1_cyc_i) begin
                    state_d = StGrant1;
                end
            end
            StGrant0: begin
                if (!m0_cyc_i) begin
                    last_owner_d = 1'b0;
                    // Direct hand-off avoids an idle bubble when the other master waits.
                    state_d      = m1_cyc_i ? StGrant1 : StIdle;
                end
            end
            StGrant1: begin
                if (!m1_cyc_i) begin
                    last_owner_d = 1'b1;
                    state_d      = m0_cyc_i ? StGrant0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: slave bus and terminations follow the current owner only
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_cti_o  = '0;
        s_bte_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        unique case (state_q)
            StGrant0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_cti_o  = m0_cti_i;
                s_bte_o  = m0_bte_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i;
                m0_rty_o = s_rty_i;
            end
            StGrant1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_cti_o  = m1_cti_i;
                s_bte_o  = m1_bte_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i;
                m1_rty_o = s_rty_i;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; only the owner's ack qualifies it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

`ifdef WB_SRAM_ARB_STATS_EN
    logic [15:0] wait0_q, wait0_d;
    logic [15:0] wait1_q, wait1_d;

    always_comb begin
        wait0_d = wait0_q;
        wait1_d = wait1_q;
        if (stats_clr_i) begin
            wait0_d = '0;
            wait1_d = '0;
        end else begin
            if (m0_cyc_i && (state_q != StGrant0) && (wait0_q != 16'hFFFF)) begin
                wait0_d = wait0_q + 16'd1;
            end
            if (m1_cyc_i && (state_q != StGrant1) && (wait1_q != 16'hFFFF)) begin
                wait1_d = wait1_q + 16'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wait0_q <= '0;
            wait1_q <= '0;
        end else begin
            wait0_q <= wait0_d;
            wait1_q <= wait1_d;
        end
    end

    assign m0_wait_cnt_o = wait0_q;
    assign m1_wait_cnt_o = wait1_q;
`endif

endmodule

// File: tb/tb_wb_sram_arb2.sv
// Self-checking bench for wb_sram_arb2: hand-computed vector table, directed multi-cycle
// sequences (round-robin, burst lock, async reset, optional wait counters) and randomized
// traffic compared against an ownership-level reference model.
module tb_wb_sram_arb2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0] m0_adr, m1_adr, s_adr_o;
    logic [DW-1:0] m0_dat, m1_dat, m0_dat_o, m1_dat_o, s_dat_o, s_dat;
    logic [SW-1:0] m0_sel, m1_sel, s_sel_o;
    logic          m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
    logic [2:0]    m0_cti, m1_cti, s_cti_o;
    logic [1:0]    m0_bte, m1_bte, s_bte_o;
    logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic          s_we_o, s_cyc_o, s_stb_o;
    logic          s_ack, s_err, s_rty;
`ifdef WB_SRAM_ARB_STATS_EN
    logic          stats_clr;
    logic [15:0]   m0_wait_cnt_o, m1_wait_cnt_o;
    int            w0, w1;
`endif

    wb_sram_arb2 #(.AW(AW), .DW(DW)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
`ifdef WB_SRAM_ARB_STATS_EN
        .stats_clr_i   (stats_clr),
        .m0_wait_cnt_o (m0_wait_cnt_o),
        .m1_wait_cnt_o (m1_wait_cnt_o),
`endif
        .m0_adr_i (m0_adr), .m0_dat_i (m0_dat), .m0_sel_i (m0_sel), .m0_we_i (m0_we),
        .m0_cyc_i (m0_cyc), .m0_stb_i (m0_stb), .m0_cti_i (m0_cti), .m0_bte_i (m0_bte),
        .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o), .m0_rty_o (m0_rty_o),
        .m1_adr_i (m1_adr), .m1_dat_i (m1_dat), .m1_sel_i (m1_sel), .m1_we_i (m1_we),
        .m1_cyc_i (m1_cyc), .m1_stb_i (m1_stb), .m1_cti_i (m1_cti), .m1_bte_i (m1_bte),
        .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o), .m1_rty_o (m1_rty_o),
        .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o), .s_we_o (s_we_o),
        .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_cti_o (s_cti_o), .s_bte_o (s_bte_o),
        .s_dat_i (s_dat), .s_ack_i (s_ack), .s_err_i (s_err), .s_rty_i (s_rty)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (-1 none) and who owned it last.
    int owner, last;

    task automatic model_reset();
        owner = -1;
        last  = 1;
`ifdef WB_SRAM_ARB_STATS_EN
        w0 = 0;
        w1 = 0;
`endif
    endtask

    // Apply the arbitration rules at a clock edge using the inputs seen at that edge.
    task automatic model_edge();
        logic cur, oth;
`ifdef WB_SRAM_ARB_STATS_EN
        if (stats_clr) begin
            w0 = 0;
            w1 = 0;
        end else begin
            if (m0_cyc && owner != 0 && w0 < 65535) w0++;
            if (m1_cyc && owner != 1 && w1 < 65535) w1++;
        end
`endif
        if (owner < 0) begin
            if (m0_cyc && m1_cyc) owner = (last == 1) ? 0 : 1;
            else if (m0_cyc)      owner = 0;
            else if (m1_cyc)      owner = 1;
        end else begin
            cur = (owner == 0) ? m0_cyc : m1_cyc;
            oth = (owner == 0) ? m1_cyc : m0_cyc;
            if (!cur) begin
                last  = owner;
                owner = oth ? 1 - owner : -1;
            end
        end
    endtask

    task automatic check_model();
        chk("mdl s_cyc", s_cyc_o, owner == 0 ? m0_cyc : owner == 1 ? m1_cyc : 1'b0);
        chk("mdl s_stb", s_stb_o, owner == 0 ? m0_stb : owner == 1 ? m1_stb : 1'b0);
        if (owner >= 0) begin
            chk("mdl s_adr", s_adr_o, owner == 0 ? m0_adr : m1_adr);
            chk("mdl s_dat", s_dat_o, owner == 0 ? m0_dat : m1_dat);
            chk("mdl s_sel", s_sel_o, owner == 0 ? m0_sel : m1_sel);
            chk("mdl s_we",  s_we_o,  owner == 0 ? m0_we  : m1_we);
            chk("mdl s_cti", s_cti_o, owner == 0 ? m0_cti : m1_cti);
            chk("mdl s_bte", s_bte_o, owner == 0 ? m0_bte : m1_bte);
        end
        chk("mdl m0_ack", m0_ack_o, owner == 0 ? s_ack : 1'b0);
        chk("mdl m0_err", m0_err_o, owner == 0 ? s_err : 1'b0);
        chk("mdl m0_rty", m0_rty_o, owner == 0 ? s_rty : 1'b0);
        chk("mdl m1_ack", m1_ack_o, owner == 1 ? s_ack : 1'b0);
        chk("mdl m1_err", m1_err_o, owner == 1 ? s_err : 1'b0);
        chk("mdl m1_rty", m1_rty_o, owner == 1 ? s_rty : 1'b0);
        chk("mdl m0_dat", m0_dat_o, s_dat);
        chk("mdl m1_dat", m1_dat_o, s_dat);
`ifdef WB_SRAM_ARB_STATS_EN
        chk("mdl m0_wait", m0_wait_cnt_o, w0[15:0]);
        chk("mdl m1_wait", m1_wait_cnt_o, w1[15:0]);
`endif
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step(input bit do_chk);
        #1;
        if (do_chk) check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_adr = 32'h10; m1_adr = 32'h20;
        m0_dat = 32'h0000_1111; m1_dat = 32'h0000_2222;
        m0_sel = '1; m1_sel = '1;
        m0_we = 1'b1; m1_we = 1'b0;
        m0_cyc = 1'b0; m1_cyc = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
        m0_cti = 3'b000; m1_cti = 3'b000; m0_bte = 2'b00; m1_bte = 2'b00;
        s_dat = 32'hCAFE_BABE; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
`ifdef WB_SRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit c0, c1, ack, err;
        int own;                 // expected owner (-1: none, address not checked)
        bit e_cyc, e_a0, e_a1, e_e0, e_e1;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{0, 0, 0, 0, -1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, -1, 0, 0, 0, 0, 0};  // arbitration cycle, ack ignored
        tbl[2]  = '{1, 0, 0, 0,  0, 1, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 1, 0,  0, 1, 1, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0};  // release cycle
        tbl[5]  = '{1, 1, 1, 0, -1, 0, 0, 0, 0, 0};  // contention, m0 was last
        tbl[6]  = '{1, 1, 1, 0,  1, 1, 0, 1, 0, 0};
        tbl[7]  = '{1, 0, 0, 0,  1, 0, 0, 0, 0, 0};  // m1 releases, m0 waiting
        tbl[8]  = '{1, 1, 0, 1,  0, 1, 0, 0, 1, 0};  // direct hand-off, error on write
        tbl[9]  = '{0, 1, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 1, 1, 0,  1, 1, 0, 1, 0, 0};

        do_reset();
        #1;
        chk("reset s_cyc", s_cyc_o, 0);
        chk("reset s_stb", s_stb_o, 0);
        chk("reset s_we",  s_we_o, 0);
        chk("reset acks", {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}, 0);
`ifdef WB_SRAM_ARB_STATS_EN
        chk("reset wait", {m0_wait_cnt_o, m1_wait_cnt_o}, 0);
`endif
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            m0_cyc = tbl[i].c0; m0_stb = tbl[i].c0;
            m1_cyc = tbl[i].c1; m1_stb = tbl[i].c1;
            s_ack = tbl[i].ack; s_err = tbl[i].err;
            #1;
            chk($sformatf("vec%0d s_cyc", i), s_cyc_o, tbl[i].e_cyc);
            chk($sformatf("vec%0d s_stb", i), s_stb_o, tbl[i].e_cyc);
            if (tbl[i].own >= 0)
                chk($sformatf("vec%0d s_adr", i), s_adr_o, tbl[i].own == 1 ? 32'h20 : 32'h10);
            chk($sformatf("vec%0d m0_ack", i), m0_ack_o, tbl[i].e_a0);
            chk($sformatf("vec%0d m1_ack", i), m1_ack_o, tbl[i].e_a1);
            chk($sformatf("vec%0d m0_err", i), m0_err_o, tbl[i].e_e0);
            chk($sformatf("vec%0d m1_err", i), m1_err_o, tbl[i].e_e1);
            chk($sformatf("vec%0d m0_dat", i), m0_dat_o, 32'hCAFE_BABE);
            step(1'b1);
        end

        // Round-robin over four simultaneous contentions: 0, 1, 0, 1
        do_reset();
        for (int r = 0; r < 4; r++) begin
            m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
            step(1'b1);
            #1;
            chk($sformatf("rr%0d owner adr", r), s_adr_o, (r % 2) ? 32'h20 : 32'h10);
            chk($sformatf("rr%0d s_cyc", r), s_cyc_o, 1);
            m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
            step(1'b1);
        end

        // Burst lock: m1 4-beat incrementing burst while m0 keeps requesting
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_cti = 3'b010;
        step(1'b1);
        m0_cyc = 1'b1; m0_stb = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m1_cti = (b == 3) ? 3'b111 : 3'b010;
            m1_adr = 32'h20 + 32'(b * 4);
            s_ack = 1'b1;
            #1;
            chk($sformatf("burst%0d m1_ack", b), m1_ack_o, 1);
            chk($sformatf("burst%0d m0_ack", b), m0_ack_o, 0);
            chk($sformatf("burst%0d s_cti", b), s_cti_o, m1_cti);
            step(1'b1);
        end
        m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
        step(1'b1);
        #1;
        chk("burst handoff s_cyc", s_cyc_o, 1);
        chk("burst handoff s_adr", s_adr_o, 32'h10);

        // Async reset between edges during GRANT1
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
        step(1'b1);
        #2;
        chk("pre-rst s_cyc", s_cyc_o, 1);
        rst_n = 1'b0;
        #1;
        chk("async rst s_cyc", s_cyc_o, 0);
        chk("async rst s_stb", s_stb_o, 0);
        chk("async rst m1_ack", m1_ack_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        s_ack = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step(1'b1);
        #1;
        chk("post-rst grant m0", s_adr_o, 32'h10);
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        step(1'b1);

`ifdef WB_SRAM_ARB_STATS_EN
        // m1 waits 7 cycles behind m0: 1 arbitration + 5 owned by m0 + 1 release
        do_reset();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        step(1'b1);
        for (int k = 0; k < 5; k++) step(1'b1);
        m0_cyc = 1'b0;
        step(1'b1);
        #1;
        chk("stats m1_wait=7", m1_wait_cnt_o, 16'd7);
        chk("stats m0_wait=1", m0_wait_cnt_o, 16'd1);
        stats_clr = 1'b1;
        step(1'b1);
        stats_clr = 1'b0;
        #1;
        chk("stats clr m0", m0_wait_cnt_o, 16'd0);
        chk("stats clr m1", m1_wait_cnt_o, 16'd0);
        m1_cyc = 1'b0;
        step(1'b1);

        // Saturation
        do_reset();
        m0_cyc = 1'b1;
        step(1'b1);
        m1_cyc = 1'b1;
        for (int k = 0; k < 70000; k++) step(1'b0);
        #1;
        chk("stats saturate", m1_wait_cnt_o, 16'hFFFF);
        chk("stats saturate mdl", m1_wait_cnt_o, w1[15:0]);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(3) == 0) m1_cyc = ~m1_cyc;
            m0_stb = m0_cyc & 1'($urandom);
            m1_stb = m1_cyc & 1'($urandom);
            m0_adr = $urandom; m1_adr = $urandom;
            m0_dat = $urandom; m1_dat = $urandom;
            m0_sel = SW'($urandom); m1_sel = SW'($urandom);
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            m0_cti = 3'($urandom); m1_cti = 3'($urandom);
            m0_bte = 2'($urandom); m1_bte = 2'($urandom);
            s_dat = $urandom;
            s_ack = 1'($urandom); s_err = 1'($urandom); s_rty = 1'($urandom);
`ifdef WB_SRAM_ARB_STATS_EN
            stats_clr = ($urandom_range(49) == 0);
`endif
            step(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
